gshare_btb_predictor: RTL

//  Parametrised next-PC predictor for the pipelined Harvard CPU, replacing the fixed 256-entry 2-bit predictor.

---
 rtl/gshare_btb_predictor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gshare_btb_predictor.sv
// Next-PC predictor: direct-mapped BTB (valid/jump/tag/target) plus a table of
//   saturating counters indexed by PC (bimodal) or PC ^ global history (gshare).
// Latency: prediction is combinational (0 cycles); training is visible 1 cycle later.
// Backpressure: none; lookups and training are accepted every cycle, never stalled.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   PC                  IF-stage PC to predict
//   PredictTaken        1 = redirect fetch to the BTB target
//   Prediction          predicted next PC (target or PC+1)
//   PredIdx             counter index used for PC, carried down the pipe to EX
//   BranchResolved/..   EX-stage branch training (outcome, PC, carried index, target)
//   JumpResolved/..     ID-stage jump training (squash flag, PC, target)
//   GHR                 global history register, newest outcome in bit 0
module gshare_btb_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8,
  parameter int CNT_BITS  = 2,
  parameter int GHR_BITS  = 8,
  parameter int MODE      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] PC,
  output logic                 PredictTaken,
  output logic [WORD_SIZE-1:0] Prediction,
  output logic [IDX_BITS-1:0]  PredIdx,
  input  logic                 BranchResolved,
  input  logic                 BranchTaken,
  input  logic [WORD_SIZE-1:0] ResolvedBranchPC,
  input  logic [IDX_BITS-1:0]  ResolvedBranchIdx,
  input  logic [WORD_SIZE-1:0] ActualBranchTarget,
  input  logic                 JumpResolved,
  input  logic                 JumpSquash,
  input  logic [WORD_SIZE-1:0] ResolvedJumpPC,
  input  logic [WORD_SIZE-1:0] ActualJumpTarget,
  output logic [GHR_BITS-1:0]  GHR
);

  localparam int DEPTH    = 1 << IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

  // Weakly not-taken start value and saturation ceiling.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

  // Prediction tables
  logic                 valid_tbl  [DEPTH];
  logic                 jump_tbl   [DEPTH];
  logic [TAG_BITS-1:0]  tag_tbl    [DEPTH];
  logic [WORD_SIZE-1:0] target_tbl [DEPTH];
  logic [CNT_BITS-1:0]  cnt_tbl    [DEPTH];
  logic [GHR_BITS-1:0]  ghr;

  // Lookup path
  logic [IDX_BITS-1:0]  pc_idx;
  logic [TAG_BITS-1:0]  pc_tag;
  logic [IDX_BITS-1:0]  ghr_ext;
  logic [IDX_BITS-1:0]  pred_idx;
  logic                 hit;
  logic                 take;

  always_comb begin
    pc_idx  = PC[IDX_BITS-1:0];
    pc_tag  = PC[WORD_SIZE-1:IDX_BITS];
    // Zero-extend history to index width; written this way so GHR_BITS may
    // equal IDX_BITS without a zero-width replication.
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr;
    pred_idx = (MODE == 1) ? (pc_idx ^ ghr_ext) : pc_idx;
    hit  = valid_tbl[pc_idx] && (tag_tbl[pc_idx] == pc_tag);
    // Jumps are unconditional: once in the BTB they always redirect.
    take = hit && (jump_tbl[pc_idx] || cnt_tbl[pred_idx][CNT_BITS-1]);
  end

  assign PredictTaken = take;
  assign Prediction   = take ? target_tbl[pc_idx] : (PC + WORD_SIZE'(1));
  assign PredIdx      = pred_idx;
  assign GHR          = ghr;

  // Training path
  logic [IDX_BITS-1:0]  br_idx;
  logic [TAG_BITS-1:0]  br_tag;
  logic [IDX_BITS-1:0]  jmp_idx;
  logic [TAG_BITS-1:0]  jmp_tag;
  logic                 jmp_wr;
  logic [CNT_BITS-1:0]  cnt_cur;
  logic [CNT_BITS-1:0]  cnt_upd;
  logic [GHR_BITS:0]    ghr_shift;

  always_comb begin
    br_idx  = ResolvedBranchPC[IDX_BITS-1:0];
    br_tag  = ResolvedBranchPC[WORD_SIZE-1:IDX_BITS];
    jmp_idx = ResolvedJumpPC[IDX_BITS-1:0];
    jmp_tag = ResolvedJumpPC[WORD_SIZE-1:IDX_BITS];
    // A squashed jump lies on a wrong path and must leave no trace.
    jmp_wr  = JumpResolved && !JumpSquash;

    // The counter is addressed by the index captured at fetch, not a
    // recomputed one, since the history has moved on since then.
    cnt_cur = cnt_tbl[ResolvedBranchIdx];
    cnt_upd = cnt_cur;
    if (BranchTaken) begin
      if (cnt_cur != CNT_MAX) cnt_upd = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != CNT_ZERO) cnt_upd = cnt_cur - CNT_BITS'(1);
    end

    // One bit wider than GHR so the low GHR_BITS bits are the shifted
    // history for any GHR_BITS >= 1.
    ghr_shift = {ghr, BranchTaken};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_tbl[i]  <= 1'b0;
        jump_tbl[i]   <= 1'b0;
        tag_tbl[i]    <= '0;
        target_tbl[i] <= '0;
        cnt_tbl[i]    <= CNT_INIT;
      end
      ghr <= '0;
    end else begin
      // Jump write first so that a same-index branch write below overrides
      // it: the branch in EX is the older instruction.
      if (jmp_wr) begin
        valid_tbl[jmp_idx]  <= 1'b1;
        jump_tbl[jmp_idx]   <= 1'b1;
        tag_tbl[jmp_idx]    <= jmp_tag;
        target_tbl[jmp_idx] <= ActualJumpTarget;
      end
      if (BranchResolved) begin
        valid_tbl[br_idx]  <= 1'b1;
        jump_tbl[br_idx]   <= 1'b0;
        tag_tbl[br_idx]    <= br_tag;
        target_tbl[br_idx] <= ActualBranchTarget;
        cnt_tbl[ResolvedBranchIdx] <= cnt_upd;
        ghr <= ghr_shift[GHR_BITS-1:0];
      end
    end
  end

endmodule
